// File: rtl/spike_frame_pkg.sv
// Shared definitions for the spike frame collector and host-side event consumers.
package spike_frame_pkg;

    localparam int EVT_NN       = 8;
    localparam int EVT_TS_W     = 16;
    localparam int EVT_IDX_W    = EVT_NN + 1;
    localparam int EVT_IDX_LSB  = 0;
    localparam int EVT_FNUM_LSB = EVT_NN + 1;
    localparam int EVT_W        = EVT_IDX_W + EVT_TS_W;
    localparam int FRAME_CNT_W  = 32;
    localparam int OVF_CNT_W    = 16;

    typedef struct packed {
        logic [EVT_TS_W-1:0]  fnum;
        logic [EVT_IDX_W-1:0] idx;
    } spike_evt_t;

    function automatic logic [EVT_W-1:0] pack_evt(
        input logic [EVT_TS_W-1:0]  fnum,
        input logic [EVT_IDX_W-1:0] idx
    );
        return {fnum, idx};
    endfunction

    function automatic logic [EVT_IDX_W-1:0] evt_index(input logic [EVT_W-1:0] evt);
        return evt[EVT_IDX_LSB +: EVT_IDX_W];
    endfunction

    function automatic logic [EVT_TS_W-1:0] evt_frame(input logic [EVT_W-1:0] evt);
        return evt[EVT_FNUM_LSB +: EVT_TS_W];
    endfunction

endpackage

// File: rtl/spike_frame_collector_fifo.sv
// First-word-fall-through event FIFO; extra pointer bit separates full from empty.
module spike_evt_fifo #(
    parameter int WIDTH = 25,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign valid = (wr_ptr != rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Storage write; the caller guarantees push is only raised when a slot is free or a pop frees one.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer advance; pops on an empty FIFO are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && valid) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/spike_frame_collector.sv
// Rebuilds neuron indices from the frame-start pulse, counts spikes per frame
// and queues each spike as a {frame, index} event for host readout.
module spike_frame_collector
    import spike_frame_pkg::*;
#(
    parameter int NN      = EVT_NN,
    parameter int FIFO_AW = 6,
    parameter int TS_W    = EVT_TS_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 spike_valid,
    input  logic                 spike_in,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [NN+TS_W:0]     evt_data,
    output logic [31:0]          frame_count,
    output logic [TS_W-1:0]      frame_num,
    output logic [15:0]          overflow_cnt,
    output logic                 frame_err
);

    localparam int W = NN + 1 + TS_W;

    localparam logic [NN:0]            IDX_ONE  = {{NN{1'b0}}, 1'b1};
    localparam logic [NN+1:0]          SEEN_ONE = {{(NN+1){1'b0}}, 1'b1};
    localparam logic [NN+1:0]          SEEN_MAX = '1;
    localparam logic [NN+1:0]          SLOT_N   = {1'b1, {(NN+1){1'b0}}};
    localparam logic [FRAME_CNT_W-1:0] ACC_ONE  = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [FRAME_CNT_W-1:0] ACC_MAX  = '1;
    localparam logic [TS_W-1:0]        FNUM_ONE = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [OVF_CNT_W-1:0]   OVF_ONE  = {{(OVF_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [OVF_CNT_W-1:0]   OVF_MAX  = '1;

    logic [NN:0]            slot_idx;
    logic [NN+1:0]          slot_seen;
    logic [FRAME_CNT_W-1:0] spk_acc;
    logic                   started;

    logic [NN:0]            beat_idx;
    logic [TS_W-1:0]        beat_fnum;
    logic                   spike_beat;
    logic                   evt_pop;
    logic                   fifo_full;
    logic                   fifo_push;
    logic                   evt_drop;

    // Index and frame number the current beat belongs to; a frame-start beat is slot 0 of the new frame.
    always_comb begin
        beat_idx   = slot_idx;
        beat_fnum  = frame_num;
        spike_beat = spike_valid & spike_in;
        if (frame_start) begin
            beat_idx = '0;
            if (started) begin
                beat_fnum = frame_num + FNUM_ONE;
            end
        end
    end

    assign evt_pop   = evt_valid & evt_ready;
    assign fifo_push = spike_beat & (~fifo_full | evt_pop);
    assign evt_drop  = spike_beat & fifo_full & ~evt_pop;

    // Slot tracking and per-frame spike accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_idx    <= '0;
            slot_seen   <= '0;
            spk_acc     <= '0;
            started     <= 1'b0;
            frame_count <= '0;
            frame_num   <= '0;
            frame_err   <= 1'b0;
        end else if (frame_start) begin
            slot_idx    <= spike_valid ? IDX_ONE : '0;
            slot_seen   <= spike_valid ? SEEN_ONE : '0;
            spk_acc     <= spike_beat ? ACC_ONE : '0;
            started     <= 1'b1;
            frame_count <= spk_acc;
            frame_num   <= beat_fnum;
            if (started && (slot_seen != SLOT_N)) begin
                frame_err <= 1'b1;
            end
        end else if (spike_valid) begin
            slot_idx <= slot_idx + IDX_ONE;
            if (slot_seen != SEEN_MAX) begin
                slot_seen <= slot_seen + SEEN_ONE;
            end
            if (spike_in && (spk_acc != ACC_MAX)) begin
                spk_acc <= spk_acc + ACC_ONE;
            end
        end
    end

    // Count events lost to a full FIFO, holding at the top value.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_cnt <= '0;
        end else if (evt_drop && (overflow_cnt != OVF_MAX)) begin
            overflow_cnt <= overflow_cnt + OVF_ONE;
        end
    end

    spike_evt_fifo #(
        .WIDTH (W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   ({beat_fnum, beat_idx}),
        .full  (fifo_full),
        .pop   (evt_pop),
        .dout  (evt_data),
        .valid (evt_valid)
    );

endmodule

// File: tb/tb_spike_frame_collector.sv
// Directed bench for spike_frame_collector: steady frames, short frame, overflow and resets.
module tb_spike_frame_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        spike_valid;
    logic        spike_in;
    logic        evt_valid;
    logic        evt_ready;
    logic [24:0] evt_data;
    logic [31:0] frame_count;
    logic [15:0] frame_num;
    logic [15:0] overflow_cnt;
    logic        frame_err;

    int assertions = 0;
    int failures   = 0;

    spike_frame_collector dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .spike_valid  (spike_valid),
        .spike_in     (spike_in),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_data     (evt_data),
        .frame_count  (frame_count),
        .frame_num    (frame_num),
        .overflow_cnt (overflow_cnt),
        .frame_err    (frame_err)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    function automatic logic [24:0] mk(input int f, input int i);
        logic [31:0] fv;
        logic [31:0] iv;
        fv = f;
        iv = i;
        return {fv[15:0], iv[8:0]};
    endfunction

    task automatic applyStimulus(input logic fs, input logic v, input logic s);
        frame_start = fs;
        spike_valid = v;
        spike_in    = s;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertions++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    // Directed sequence of all scenarios.
    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        spike_valid = 1'b0;
        spike_in    = 1'b0;
        evt_ready   = 1'b1;
        doReset();

        checkOutput("reset_evt_valid", 64'(evt_valid), 64'd0);
        checkOutput("reset_frame_count", 64'(frame_count), 64'd0);
        checkOutput("reset_frame_num", 64'(frame_num), 64'd0);
        checkOutput("reset_overflow", 64'(overflow_cnt), 64'd0);
        checkOutput("reset_frame_err", 64'(frame_err), 64'd0);

        // Three full frames, spikes at 0, 85, 170.
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < 512; s++) begin
                logic sp;
                sp = (s == 0) || (s == 85) || (s == 170);
                applyStimulus(s == 0, 1'b1, sp);
                if (sp) begin
                    checkOutput("steady_evt_valid", 64'(evt_valid), 64'd1);
                    checkOutput("steady_evt_data", 64'(evt_data), 64'(mk(f, s)));
                end
                if (s == 0) begin
                    checkOutput("steady_frame_count", 64'(frame_count), (f == 0) ? 64'd0 : 64'd3);
                    checkOutput("steady_frame_num", 64'(frame_num), 64'(f));
                    checkOutput("steady_frame_err", 64'(frame_err), 64'd0);
                end
            end
        end

        // Frame start coincident with a spike beat opens frame 3.
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("coinc_evt_data", 64'(evt_data), 64'(mk(3, 0)));
        checkOutput("coinc_frame_count", 64'(frame_count), 64'd3);
        checkOutput("coinc_frame_num", 64'(frame_num), 64'd3);
        checkOutput("coinc_frame_err", 64'(frame_err), 64'd0);

        // Short frame: 511 beats in total, then frame start with no beat.
        for (int s = 1; s < 511; s++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
        checkOutput("short_err_before", 64'(frame_err), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("short_frame_count", 64'(frame_count), 64'd1);
        checkOutput("short_frame_err", 64'(frame_err), 64'd1);
        checkOutput("short_frame_num", 64'(frame_num), 64'd4);

        // Good frame afterwards keeps the sticky error.
        for (int s = 0; s < 512; s++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("sticky_frame_err", 64'(frame_err), 64'd1);
        checkOutput("sticky_frame_num", 64'(frame_num), 64'd5);
        checkOutput("sticky_frame_count", 64'(frame_count), 64'd0);
        checkOutput("sticky_evt_valid", 64'(evt_valid), 64'd0);

        // Overflow: 70 spiking beats with the consumer stalled.
        doReset();
        checkOutput("rst2_frame_err", 64'(frame_err), 64'd0);
        checkOutput("rst2_frame_num", 64'(frame_num), 64'd0);
        evt_ready = 1'b0;
        for (int i = 0; i < 70; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (i == 0) begin
                checkOutput("ovf_first_evt", 64'(evt_data), 64'(mk(0, 0)));
            end
            if (i == 63) begin
                checkOutput("ovf_at_full", 64'(overflow_cnt), 64'd0);
            end
            if (i == 64) begin
                checkOutput("ovf_first_drop", 64'(overflow_cnt), 64'd1);
            end
        end
        checkOutput("ovf_count", 64'(overflow_cnt), 64'd6);
        checkOutput("ovf_evt_valid", 64'(evt_valid), 64'd1);
        checkOutput("ovf_head_stable", 64'(evt_data), 64'(mk(0, 0)));

        // Full FIFO with simultaneous push and pop: push of index 70 is kept.
        evt_ready = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("fullpp_overflow", 64'(overflow_cnt), 64'd6);
        checkOutput("fullpp_head", 64'(evt_data), 64'(mk(0, 1)));

        // Drain: indices 1..63 then 70, then empty.
        for (int k = 1; k <= 64; k++) begin
            checkOutput("drain_valid", 64'(evt_valid), 64'd1);
            checkOutput("drain_data", 64'(evt_data), 64'(mk(0, (k < 64) ? k : 70)));
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("drain_empty", 64'(evt_valid), 64'd0);

        // Mid-frame reset with 10 events queued and non-zero counters.
        evt_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("pre_rst_frame_count", 64'(frame_count), 64'd10);
        checkOutput("pre_rst_frame_num", 64'(frame_num), 64'd1);
        checkOutput("pre_rst_frame_err", 64'(frame_err), 64'd1);
        checkOutput("pre_rst_head", 64'(evt_data), 64'(mk(0, 0)));

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rst_evt_valid", 64'(evt_valid), 64'd0);
        checkOutput("rst_frame_count", 64'(frame_count), 64'd0);
        checkOutput("rst_frame_num", 64'(frame_num), 64'd0);
        checkOutput("rst_overflow", 64'(overflow_cnt), 64'd0);
        checkOutput("rst_frame_err", 64'(frame_err), 64'd0);
        reset = 1'b0;

        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("post_rst_valid", 64'(evt_valid), 64'd1);
        checkOutput("post_rst_evt", 64'(evt_data), 64'(mk(0, 0)));
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("post_rst_hold", 64'(evt_data), 64'(mk(0, 0)));
        evt_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("post_rst_second", 64'(evt_data), 64'(mk(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
